// File: rtl/axil_read_arbiter_pkg.sv
// axil_read_arbiter_pkg
//   Shared constants for the two-port AXI-Lite read arbiter: FSM state
//   encodings and the AXI read response codes.
package axil_read_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'b00;
  localparam arb_state_t ARB_ADDR = 2'b01;
  localparam arb_state_t ARB_DATA = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axil_read_arbiter_if.sv
// axil_read_arbiter_if
//   AXI-Lite read channels (AR + R) bundled as one interface.
//   master : drives araddr/arvalid/rready, receives arready/rdata/rresp/rvalid
//   slave  : the mirror image
interface axil_read_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_read_arbiter_rr_arbiter_2.sv
// rr_arbiter_2
//   Combinational two-requester arbiter.
//   req        : request bits, bit N = port N
//   last_grant : port that completed the most recent transaction
//   gnt        : one-hot grant (all zero when nothing requests)
//   gnt_idx    : index of the granted port
//   FIXED_PRIORITY = 1 makes port 0 win every contention; otherwise the
//   port that did not win last time gets it.
module rr_arbiter_2 #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    gnt_idx = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
      default: gnt_idx = 1'b0;
    endcase
    gnt = 2'b00;
    if (req != 2'b00) begin
      gnt = gnt_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/axil_read_arbiter.sv
// axil_read_arbiter
//   Shares one AXI-Lite read master between port 0 (instruction fetch) and
//   port 1 (data load), one transaction in flight at a time.
//   i_Clock   : clock, posedge
//   i_Reset_N : synchronous active-low reset
//   s0_axil   : requester port 0 (arbiter acts as slave)
//   s1_axil   : requester port 1 (arbiter acts as slave)
//   m_axil    : downstream read master
//   o_Busy    : high whenever the FSM is not idle
//   o_Grant   : port owning the current transaction
//
//   state    | meaning
//   ARB_IDLE | waiting for a request; winner's arready driven this cycle
//   ARB_ADDR | latched address presented downstream until arready
//   ARB_DATA | read data routed to the granted port until rvalid&&rready
module axil_read_arbiter
  import axil_read_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                i_Clock,
  input  logic                i_Reset_N,
  axil_read_arbiter_if.slave  s0_axil,
  axil_read_arbiter_if.slave  s1_axil,
  axil_read_arbiter_if.master m_axil,
  output logic                o_Busy,
  output logic                o_Grant
);

  arb_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       gnt_idx;
  logic       in_idle, in_addr, in_data;
  logic       sel0, sel1;
  logic       m_rready;

  assign req = {s1_axil.arvalid, s0_axil.arvalid};

  rr_arbiter_2 #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_rr_arbiter_2 (
    .req       (req),
    .last_grant(last_grant_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx)
  );

  // Outputs are gated by the reset input itself so they read zero for the
  // whole time reset is held, not only after the first sampling edge.
  assign in_idle = i_Reset_N && (state_q == ARB_IDLE);
  assign in_addr = i_Reset_N && (state_q == ARB_ADDR);
  assign in_data = i_Reset_N && (state_q == ARB_DATA);
  assign sel0    = in_data && !grant_q;
  assign sel1    = in_data &&  grant_q;

  assign m_rready = (sel0 && s0_axil.rready) || (sel1 && s1_axil.rready);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (req != 2'b00) begin
          addr_d  = gnt_idx ? s1_axil.araddr : s0_axil.araddr;
          grant_d = gnt_idx;
          state_d = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (m_axil.arready) begin
          state_d = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (m_axil.rvalid && m_rready) begin
          last_grant_d = grant_q;
          state_d      = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N) begin
      state_q      <= ARB_IDLE;
      addr_q       <= '0;
      grant_q      <= 1'b0;
      // Port 1 counts as the previous winner so port 0 takes the first tie.
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign s0_axil.arready = in_idle && gnt[0];
  assign s1_axil.arready = in_idle && gnt[1];

  assign m_axil.arvalid = in_addr;
  assign m_axil.araddr  = i_Reset_N ? addr_q : '0;
  assign m_axil.rready  = m_rready;

  assign s0_axil.rvalid = sel0 && m_axil.rvalid;
  assign s0_axil.rdata  = sel0 ? m_axil.rdata : '0;
  assign s0_axil.rresp  = sel0 ? m_axil.rresp : OKAY;

  assign s1_axil.rvalid = sel1 && m_axil.rvalid;
  assign s1_axil.rdata  = sel1 ? m_axil.rdata : '0;
  assign s1_axil.rresp  = sel1 ? m_axil.rresp : OKAY;

  assign o_Busy  = i_Reset_N && (state_q != ARB_IDLE);
  assign o_Grant = i_Reset_N && grant_q;

endmodule

// File: tb/tb_axil_read_arbiter.sv
module tb_axil_read_arbiter;
  import axil_read_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s0_if ();
  axil_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s1_if ();
  axil_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();
  axil_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) f0_if ();
  axil_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) f1_if ();
  axil_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fm_if ();

  logic busy, grant, f_busy, f_grant;

  axil_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(0)) dut (
    .i_Clock(clk), .i_Reset_N(rst_n),
    .s0_axil(s0_if), .s1_axil(s1_if), .m_axil(m_if),
    .o_Busy(busy), .o_Grant(grant)
  );

  axil_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1)) dut_fp (
    .i_Clock(clk), .i_Reset_N(rst_n),
    .s0_axil(f0_if), .s1_axil(f1_if), .m_axil(fm_if),
    .o_Busy(f_busy), .o_Grant(f_grant)
  );

  typedef struct {
    bit          port;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  int total = 0;
  int bad   = 0;

  exp_t        exp_q[$];
  logic [31:0] req_q0[$];
  logic [31:0] req_q1[$];
  bit          grant_log[$];

  int  ar_stall_cfg = 0;
  int  stall        = 0;
  bit  ar_active    = 0;
  bit  ar_hs_seen = 0, r_hs_seen = 0, acc0_seen = 0, acc1_seen = 0, rst_seen = 1;
  logic [31:0] ar_hs_addr = '0;

  bit          prev_arvalid = 0, prev_arready = 0, prev_s0_rvalid = 0, prev_s0_rready = 0;
  logic [31:0] prev_araddr = '0, prev_s0_rdata = '0;

  // Memory model: each address maps to a distinct word; 0x2000 -> 0xDEADBEEF.
  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return a ^ 32'hDEAD_9EEF;
  endfunction

  function automatic logic [1:0] slave_resp(input logic [31:0] a);
    return (a[31:28] == 4'hE) ? SLVERR : OKAY;
  endfunction

  // Downstream slave and both requesters, driven at the falling edge from
  // what the sampler observed just before the previous rising edge.
  initial begin
    s0_if.araddr = '0; s0_if.arvalid = 0; s0_if.rready = 1;
    s1_if.araddr = '0; s1_if.arvalid = 0; s1_if.rready = 1;
    m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = '0; m_if.rresp = OKAY;
    f0_if.araddr = 32'h0000_0A00; f0_if.arvalid = 0; f0_if.rready = 1;
    f1_if.araddr = 32'h0000_0B00; f1_if.arvalid = 0; f1_if.rready = 1;
    fm_if.arready = 1; fm_if.rvalid = 1; fm_if.rdata = 32'hC0DE_0000; fm_if.rresp = OKAY;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        m_if.rvalid  = 0;
        m_if.arready = 0;
        ar_active    = 0;
      end else begin
        if (r_hs_seen) m_if.rvalid = 0;
        if (ar_hs_seen) begin
          m_if.rvalid  = 1;
          m_if.rdata   = slave_data(ar_hs_addr);
          m_if.rresp   = slave_resp(ar_hs_addr);
          m_if.arready = 0;
          ar_active    = 0;
        end
        if (m_if.arvalid && !ar_active) begin
          ar_active = 1;
          stall     = ar_stall_cfg;
        end
        if (ar_active) begin
          m_if.arready = (stall == 0);
          if (stall > 0) stall--;
        end
      end
      if (acc0_seen) s0_if.arvalid = 0;
      if (!s0_if.arvalid && req_q0.size() > 0) begin
        s0_if.araddr  = req_q0.pop_front();
        s0_if.arvalid = 1;
      end
      if (acc1_seen) s1_if.arvalid = 0;
      if (!s1_if.arvalid && req_q1.size() > 0) begin
        s1_if.araddr  = req_q1.pop_front();
        s1_if.arvalid = 1;
      end
    end
  end

  // Sampler / scoreboard: runs 3 ns after the falling edge, before the tasks.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      rst_seen = !rst_n;
      if (!rst_n) begin
        exp_q.delete();
        ar_hs_seen = 0; r_hs_seen = 0; acc0_seen = 0; acc1_seen = 0;
        prev_arvalid = 0; prev_arready = 0; prev_s0_rvalid = 0; prev_s0_rready = 0;
      end else begin
        ar_hs_seen = m_if.arvalid && m_if.arready;
        ar_hs_addr = m_if.araddr;
        r_hs_seen  = m_if.rvalid && m_if.rready;
        acc0_seen  = s0_if.arvalid && s0_if.arready;
        acc1_seen  = s1_if.arvalid && s1_if.arready;
        if (acc0_seen || acc1_seen) begin
          total++;
          if (acc0_seen && acc1_seen) begin
            bad++;
            $display("FAIL single_winner: both arready high, required one");
          end
        end
        if (acc0_seen) begin
          exp_q.push_back('{port: 1'b0, data: slave_data(s0_if.araddr), resp: slave_resp(s0_if.araddr)});
          grant_log.push_back(1'b0);
        end
        if (acc1_seen) begin
          exp_q.push_back('{port: 1'b1, data: slave_data(s1_if.araddr), resp: slave_resp(s1_if.araddr)});
          grant_log.push_back(1'b1);
        end
        if (s0_if.rvalid && s0_if.rready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL s0_unexpected_rdata: got %h, required no response", s0_if.rdata);
          end else begin
            e = exp_q.pop_front();
            if (e.port !== 1'b0 || s0_if.rdata !== e.data || s0_if.rresp !== e.resp) begin
              bad++;
              $display("FAIL s0_response: got port0 data %h resp %b, required port%0d data %h resp %b",
                       s0_if.rdata, s0_if.rresp, e.port, e.data, e.resp);
            end
          end
        end
        if (s1_if.rvalid && s1_if.rready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL s1_unexpected_rdata: got %h, required no response", s1_if.rdata);
          end else begin
            e = exp_q.pop_front();
            if (e.port !== 1'b1 || s1_if.rdata !== e.data || s1_if.rresp !== e.resp) begin
              bad++;
              $display("FAIL s1_response: got port1 data %h resp %b, required port%0d data %h resp %b",
                       s1_if.rdata, s1_if.rresp, e.port, e.data, e.resp);
            end
          end
        end
        if (s0_if.rvalid && s1_if.rvalid) begin
          total++; bad++;
          $display("FAIL rvalid_exclusive: both rvalid high, required one");
        end
        if (prev_arvalid && !prev_arready) begin
          total++;
          if (m_if.arvalid !== 1'b1 || m_if.araddr !== prev_araddr) begin
            bad++;
            $display("FAIL araddr_hold: got arvalid %b addr %h, required 1 addr %h",
                     m_if.arvalid, m_if.araddr, prev_araddr);
          end
        end
        if (prev_s0_rvalid && !prev_s0_rready) begin
          total++;
          if (s0_if.rvalid !== 1'b1 || s0_if.rdata !== prev_s0_rdata) begin
            bad++;
            $display("FAIL rdata_hold: got rvalid %b data %h, required 1 data %h",
                     s0_if.rvalid, s0_if.rdata, prev_s0_rdata);
          end
        end
        prev_arvalid   = m_if.arvalid;
        prev_arready   = m_if.arready;
        prev_araddr    = m_if.araddr;
        prev_s0_rvalid = s0_if.rvalid;
        prev_s0_rready = s0_if.rready;
        prev_s0_rdata  = s0_if.rdata;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #4;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    #4;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      done = (req_q0.size() == 0) && (req_q1.size() == 0) && !s0_if.arvalid &&
             !s1_if.arvalid && !busy && (exp_q.size() == 0);
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_drain: still busy=%b pending=%0d after 100 cycles, required idle",
               name, busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    req_q0.push_back(32'h0000_0100);
    repeat (3) tick();
    outs = {s0_if.arready, s1_if.arready, m_if.arvalid, m_if.rready,
            s0_if.rvalid, s1_if.rvalid, busy, grant};
    total++;
    if (outs !== 8'h00 || s0_if.arvalid !== 1'b1) begin
      bad++;
      $display("FAIL reset_outputs: got %b (s0 arvalid %b), required 00000000 with arvalid 1",
               outs, s0_if.arvalid);
    end
    total++;
    if (m_if.araddr !== 32'h0) begin
      bad++;
      $display("FAIL reset_araddr: got %h, required 00000000", m_if.araddr);
    end
    @(negedge clk);
    rst_n = 1;
    wait_idle("reset");
  endtask

  task automatic test_single();
    bit found = 0;
    req_q0.push_back(32'h0000_2000);
    for (int i = 0; i < 5 && !found; i++) begin
      tick();
      found = s0_if.arvalid && s0_if.arready;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL single_accept: s0 arready never seen, required within 5 cycles");
    end
    tick();
    total++;
    if (m_if.arvalid !== 1'b1 || m_if.araddr !== 32'h0000_2000) begin
      bad++;
      $display("FAIL single_cycle1: got arvalid %b addr %h, required 1 addr 00002000",
               m_if.arvalid, m_if.araddr);
    end
    tick();
    total++;
    if (s0_if.rvalid !== 1'b1 || s0_if.rdata !== 32'hDEAD_BEEF || s1_if.rvalid !== 1'b0) begin
      bad++;
      $display("FAIL single_cycle2: got s0 rvalid %b rdata %h s1 rvalid %b, required 1 deadbeef 0",
               s0_if.rvalid, s0_if.rdata, s1_if.rvalid);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL single_cycle3: got busy %b, required 0", busy);
    end
    wait_idle("single");
  endtask

  task automatic test_rr_contention();
    bit want[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    pulse_reset();
    grant_log.delete();
    req_q0.push_back(32'h0000_1000); req_q0.push_back(32'h0000_1004);
    req_q1.push_back(32'h0000_5000); req_q1.push_back(32'h0000_5004);
    for (int i = 0; i < 40 && grant_log.size() < 4; i++) tick();
    total++;
    if (grant_log.size() < 4) begin
      bad++;
      $display("FAIL rr_grants: got %0d grants, required 4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (grant_log[i] !== want[i]) begin
          bad++;
          $display("FAIL rr_order[%0d]: got port %0d, required port %0d", i, grant_log[i], want[i]);
        end
      end
    end
    wait_idle("rr");
  endtask

  task automatic test_fixed_priority();
    int  s0_wins = 0;
    int  s1_wins = 0;
    bit  found = 0;
    @(negedge clk);
    f0_if.arvalid = 1;
    f1_if.arvalid = 1;
    #4;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (f0_if.arready) s0_wins++;
      if (f1_if.arready) s1_wins++;
    end
    total++;
    if (s1_wins != 0 || s0_wins != 4) begin
      bad++;
      $display("FAIL fp_contention: got s0 %0d s1 %0d grants, required 4 and 0", s0_wins, s1_wins);
    end
    for (int i = 0; i < 4 && !found; i++) begin
      tick();
      found = f0_if.arready;
    end
    @(negedge clk);
    f0_if.arvalid = 0;
    #4;
    tick();
    total++;
    if (!found || f1_if.arready !== 1'b0) begin
      bad++;
      $display("FAIL fp_wait: got found %b s1 arready %b in DATA, required 1 and 0", found, f1_if.arready);
    end
    tick();
    total++;
    if (f1_if.arready !== 1'b1) begin
      bad++;
      $display("FAIL fp_handover: got s1 arready %b in first IDLE, required 1", f1_if.arready);
    end
    @(negedge clk);
    f1_if.arvalid = 0;
    #4;
  endtask

  task automatic test_backpressure();
    bit   seen = 0;
    int   n = 0;
    logic [31:0] want = slave_data(32'h0000_3000);
    ar_stall_cfg = 5;
    @(negedge clk);
    s0_if.rready = 0;
    #4;
    req_q0.push_back(32'h0000_3000);
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      seen = m_if.arvalid;
    end
    while (m_if.arvalid && n < 20) begin
      n++;
      total++;
      if (m_if.araddr !== 32'h0000_3000 || busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_addr: got addr %h busy %b, required 00003000 1", m_if.araddr, busy);
      end
      tick();
    end
    total++;
    if (n != 6) begin
      bad++;
      $display("FAIL bp_addr_cycles: got %0d ADDR cycles, required 6", n);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (s0_if.rvalid !== 1'b1 || s0_if.rdata !== want || busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_rhold[%0d]: got rvalid %b rdata %h busy %b, required 1 %h 1",
                 k, s0_if.rvalid, s0_if.rdata, busy, want);
      end
      if (k < 2) tick();
    end
    @(negedge clk);
    s0_if.rready = 1;
    #4;
    total++;
    if (s0_if.rvalid !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got rvalid %b, required 1", s0_if.rvalid);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_done: got busy %b, required 0", busy);
    end
    ar_stall_cfg = 0;
    wait_idle("bp");
  endtask

  task automatic test_slverr();
    bit seen = 0;
    req_q1.push_back(32'hE000_0010);
    req_q0.push_back(32'h0000_4000);
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = s1_if.rvalid;
    end
    total++;
    if (!seen || s1_if.rresp !== SLVERR || s0_if.rvalid !== 1'b0 || s0_if.rresp !== OKAY) begin
      bad++;
      $display("FAIL slverr: got seen %b s1 rresp %b s0 rvalid %b s0 rresp %b, required 1 10 0 00",
               seen, s1_if.rresp, s0_if.rvalid, s0_if.rresp);
    end
    wait_idle("slverr");
  endtask

  task automatic test_reset_mid_data();
    bit seen = 0;
    logic [5:0] v;
    req_q0.push_back(32'h0000_6000);
    wait_idle("pre_mid");
    @(negedge clk);
    s1_if.rready = 0;
    #4;
    req_q1.push_back(32'h0000_7000);
    for (int i = 0; i < 15 && !seen; i++) begin
      tick();
      seen = s1_if.rvalid;
    end
    @(negedge clk);
    rst_n = 0;
    #4;
    v = {s0_if.rvalid, s1_if.rvalid, m_if.arvalid, m_if.rready, s0_if.arready, s1_if.arready};
    total++;
    if (!seen || v !== 6'b0) begin
      bad++;
      $display("FAIL mid_reset_valids: got seen %b valids %b, required 1 000000", seen, v);
    end
    @(negedge clk);
    rst_n = 1;
    s1_if.rready = 1;
    #4;
    total++;
    if (busy !== 1'b0 || s1_if.rvalid !== 1'b0 || m_if.arvalid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_idle: got busy %b s1 rvalid %b arvalid %b, required 0 0 0",
               busy, s1_if.rvalid, m_if.arvalid);
    end
    grant_log.delete();
    req_q0.push_back(32'h0000_8000);
    req_q1.push_back(32'h0000_9000);
    for (int i = 0; i < 10 && grant_log.size() < 1; i++) tick();
    total++;
    if (grant_log.size() < 1 || grant_log[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_first_grant: got %0d grants first %0d, required port 0",
               grant_log.size(), (grant_log.size() > 0) ? int'(grant_log[0]) : -1);
    end
    wait_idle("post_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_contention();
    test_fixed_priority();
    test_backpressure();
    test_slverr();
    test_reset_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 500000 ns, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
